// File: rtl/stepper_seq.sv
// stepper_seq: segment FIFO plus issue sequencer that feeds stepper_ctrl.
// Segments are popped and launched with a registered one-cycle start pulse;
// each done pulse launches the next queued segment one cycle later.
module stepper_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          abort,
    input  logic          wr_en,
    input  logic [31:0]   wr_time,
    input  logic [31:0]   wr_position,
    input  logic          wr_relative,
    input  logic          clr_flags,
    input  logic          done,
    output logic          start,
    output logic [31:0]   target_time,
    output logic [31:0]   target_position,
    output logic          relative,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underrun,
    output logic [31:0]   seg_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    state_t         state_q, state_d;
    logic           start_q, start_d;
    logic [31:0]    tgt_time_q, tgt_time_d;
    logic [31:0]    tgt_pos_q, tgt_pos_d;
    logic           tgt_rel_q, tgt_rel_d;
    logic           overflow_q, overflow_d;
    logic           underrun_q, underrun_d;
    logic [31:0]    seg_count_q, seg_count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;

    logic [31:0]    mem_time [DEPTH];
    logic [31:0]    mem_pos  [DEPTH];
    logic           mem_rel  [DEPTH];

    logic           push, pop, is_full, is_empty;
    logic [31:0]    head_time, head_pos;
    logic           head_rel;

    assign is_full  = (level_q == LVL_FULL);
    assign is_empty = (level_q == '0);
    assign push     = wr_en && !is_full && !abort;

    // Head of queue; when empty the incoming write is forwarded so an idle
    // sequencer can launch in the cycle right after the write edge.
    always_comb begin
        head_time = mem_time[rd_ptr_q];
        head_pos  = mem_pos[rd_ptr_q];
        head_rel  = mem_rel[rd_ptr_q];
        if (is_empty) begin
            head_time = wr_time;
            head_pos  = wr_position;
            head_rel  = wr_relative;
        end
    end

    // FIFO storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_ptr_q] <= wr_time;
            mem_pos[wr_ptr_q]  <= wr_position;
            mem_rel[wr_ptr_q]  <= wr_relative;
        end
    end

    // Sequencer next-state: issue decisions, counters, sticky flags.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        tgt_time_d  = tgt_time_q;
        tgt_pos_d   = tgt_pos_q;
        tgt_rel_d   = tgt_rel_q;
        seg_count_d = seg_count_q;
        pop         = 1'b0;
        overflow_d  = clr_flags ? 1'b0 : overflow_q;
        underrun_d  = clr_flags ? 1'b0 : underrun_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            if (wr_en && is_full)
                overflow_d = 1'b1;
            case (state_q)
                IDLE: begin
                    // Forwarded write only matters here; RUN needs a stored entry.
                    if (enable && (!is_empty || push)) begin
                        pop        = 1'b1;
                        start_d    = 1'b1;
                        tgt_time_d = head_time;
                        tgt_pos_d  = head_pos;
                        tgt_rel_d  = head_rel;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (done) begin
                        seg_count_d = seg_count_q + 32'd1;
                        if (enable && !is_empty) begin
                            pop        = 1'b1;
                            start_d    = 1'b1;
                            tgt_time_d = head_time;
                            tgt_pos_d  = head_pos;
                            tgt_rel_d  = head_rel;
                        end else begin
                            state_d = IDLE;
                            if (enable)
                                underrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy update; abort flushes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)
                level_d = level_q + (AW+1)'(1);
            else if (pop && !push)
                level_d = level_q - (AW+1)'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            tgt_time_q  <= '0;
            tgt_pos_q   <= '0;
            tgt_rel_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            seg_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            tgt_time_q  <= tgt_time_d;
            tgt_pos_q   <= tgt_pos_d;
            tgt_rel_q   <= tgt_rel_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            seg_count_q <= seg_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    assign start           = start_q;
    assign target_time     = tgt_time_q;
    assign target_position = tgt_pos_q;
    assign relative        = tgt_rel_q;
    assign busy            = (state_q == RUN);
    assign full            = is_full;
    assign empty           = is_empty;
    assign level           = level_q;
    assign overflow        = overflow_q;
    assign underrun        = underrun_q;
    assign seg_count       = seg_count_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Directed bench for stepper_seq: hand-computed expectations per scenario.
module tb_stepper_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0, abort = 1'b0, wr_en = 1'b0, wr_relative = 1'b0;
    logic        clr_flags = 1'b0, done = 1'b0;
    logic [31:0] wr_time = '0, wr_position = '0;
    logic        start, relative, busy, full, empty, overflow, underrun;
    logic [31:0] target_time, target_position, seg_count;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    stepper_seq #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .abort(abort),
        .wr_en(wr_en), .wr_time(wr_time), .wr_position(wr_position),
        .wr_relative(wr_relative), .clr_flags(clr_flags), .done(done),
        .start(start), .target_time(target_time), .target_position(target_position),
        .relative(relative), .busy(busy), .full(full), .empty(empty),
        .level(level), .overflow(overflow), .underrun(underrun), .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; abort = 1'b0; wr_en = 1'b0;
        clr_flags = 1'b0; done = 1'b0; wr_relative = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic push(input logic [31:0] t, input logic [31:0] p, input logic r);
        wr_en = 1'b1; wr_time = t; wr_position = p; wr_relative = r;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_checks++;
        if ({start, busy, full, empty, overflow, underrun} !== 6'b000100 ||
            level !== 5'd0 || seg_count !== 32'd0 || target_time !== 32'd0 ||
            target_position !== 32'd0 || relative !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: start=%0b busy=%0b full=%0b empty=%0b lvl=%0d cnt=%0d tt=%0d want empty=1 rest 0",
                     start, busy, full, empty, level, seg_count, target_time);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        push(32'd20000, 32'd5, 1'b0);
        n_checks++;
        if (start !== 1'b1 || target_time !== 32'd20000 || target_position !== 32'd5 ||
            busy !== 1'b1 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL single_issue: start=%0b tt=%0d tp=%0d busy=%0b lvl=%0d want 1 20000 5 1 0",
                     start, target_time, target_position, busy, level);
        end
        step();
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_pulse: start=%0b want 0", start);
        end
        done = 1'b1; step(); done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || seg_count !== 32'd1 || underrun !== 1'b1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: busy=%0b cnt=%0d underrun=%0b start=%0b want 0 1 1 0",
                     busy, seg_count, underrun, start);
        end
        // done while IDLE is ignored
        done = 1'b1; step(); done = 1'b0;
        n_checks++;
        if (seg_count !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_ignored: cnt=%0d busy=%0b want 1 0", seg_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tt [5];
        logic [31:0] tp [5];
        logic        tr [5];
        tt = '{32'd50000, 32'd17000, 32'd50000, 32'd10000, 32'd15000};
        tp = '{-32'sd15, -32'sd10, 32'd10, 32'd10, -32'sd20};
        tr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) push(tt[i], tp[i], tr[i]);
        n_checks++;
        if (level !== 5'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL chain_queued: lvl=%0d busy=%0b want 5 0", level, busy);
        end
        enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (start !== 1'b1 || target_time !== tt[i] || target_position !== tp[i] ||
                relative !== tr[i] || level !== 5'(4 - i)) begin
                n_fail++;
                $display("FAIL chain_seg%0d: start=%0b tt=%0d tp=%0d rel=%0b lvl=%0d want 1 %0d %0d %0b %0d",
                         i, start, target_time, $signed(target_position), relative, level,
                         tt[i], $signed(tp[i]), tr[i], 4 - i);
            end
            step();
            n_checks++;
            if (start !== 1'b0) begin
                n_fail++;
                $display("FAIL chain_start_double%0d: start=%0b want 0", i, start);
            end
            step();
            done = 1'b1; step(); done = 1'b0;
        end
        n_checks++;
        if (seg_count !== 32'd5 || busy !== 1'b0 || start !== 1'b0 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_end: cnt=%0d busy=%0b start=%0b underrun=%0b want 5 0 0 1",
                     seg_count, busy, start, underrun);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) push(32'd100 + 32'(i), 32'(i), 1'b0);
        n_checks++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: full=%0b lvl=%0d ovf=%0b want 1 16 0", full, level, overflow);
        end
        push(32'd999, 32'd999, 1'b0);
        n_checks++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_17th: full=%0b lvl=%0d ovf=%0b want 1 16 1", full, level, overflow);
        end
        // set wins over clear in the same cycle
        clr_flags = 1'b1; wr_en = 1'b1; step(); wr_en = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf=%0b want 1", overflow);
        end
        step(); clr_flags = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%0b lvl=%0d want 0 16", overflow, level);
        end
        enable = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (start !== 1'b1 || target_time !== 32'd100 + 32'(i) || target_position !== 32'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: start=%0b tt=%0d tp=%0d want 1 %0d %0d",
                         i, start, target_time, target_position, 100 + i, i);
            end
            step();
            done = 1'b1; step(); done = 1'b0;
        end
        n_checks++;
        if (seg_count !== 32'd16 || level !== 5'd0 || busy !== 1'b0 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain_end: cnt=%0d lvl=%0d busy=%0b start=%0b want 16 0 0 0",
                     seg_count, level, busy, start);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        push(32'd11, 32'd1, 1'b0);
        push(32'd22, 32'd2, 1'b1);
        push(32'd33, 32'd3, 1'b0);
        enable = 1'b1; step(); enable = 1'b0;
        n_checks++;
        if (start !== 1'b1 || target_time !== 32'd11 || level !== 5'd2) begin
            n_fail++;
            $display("FAIL gate_first: start=%0b tt=%0d lvl=%0d want 1 11 2", start, target_time, level);
        end
        step();
        done = 1'b1; step(); done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || underrun !== 1'b0 || level !== 5'd2 || start !== 1'b0 ||
            seg_count !== 32'd1) begin
            n_fail++;
            $display("FAIL gate_idle: busy=%0b underrun=%0b lvl=%0d start=%0b cnt=%0d want 0 0 2 0 1",
                     busy, underrun, level, start, seg_count);
        end
        step();
        n_checks++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_hold: start=%0b busy=%0b want 0 0", start, busy);
        end
        enable = 1'b1; step();
        n_checks++;
        if (start !== 1'b1 || target_time !== 32'd22 || relative !== 1'b1 || level !== 5'd1) begin
            n_fail++;
            $display("FAIL gate_resume: start=%0b tt=%0d rel=%0b lvl=%0d want 1 22 1 1",
                     start, target_time, relative, level);
        end
    endtask

    task automatic test_abort();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'd500 + 32'(i), 32'd7, 1'b0);
        enable = 1'b1; step();
        n_checks++;
        if (start !== 1'b1 || busy !== 1'b1 || level !== 5'd3) begin
            n_fail++;
            $display("FAIL abort_setup: start=%0b busy=%0b lvl=%0d want 1 1 3", start, busy, level);
        end
        step();
        abort = 1'b1; wr_en = 1'b1; done = 1'b1; wr_time = 32'd77;
        step();
        abort = 1'b0; wr_en = 1'b0; done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || level !== 5'd0 || empty !== 1'b1 || seg_count !== 32'd0 ||
            start !== 1'b0 || target_time !== 32'd500) begin
            n_fail++;
            $display("FAIL abort_flush: busy=%0b lvl=%0d empty=%0b cnt=%0d start=%0b tt=%0d want 0 0 1 0 0 500",
                     busy, level, empty, seg_count, start, target_time);
        end
        step(); step();
        n_checks++;
        if (start !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: start=%0b busy=%0b underrun=%0b want 0 0 0", start, busy, underrun);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) push(32'd40 + 32'(i), 32'd1, 1'b0);
        enable = 1'b1; step(); step();
        done = 1'b1; step(); done = 1'b0;
        n_checks++;
        if (start !== 1'b1 || seg_count !== 32'd1 || level !== 5'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: start=%0b cnt=%0d lvl=%0d busy=%0b want 1 1 1 1",
                     start, seg_count, level, busy);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (start !== 1'b0 || busy !== 1'b0 || level !== 5'd0 || seg_count !== 32'd0 ||
            empty !== 1'b1 || target_time !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_async: start=%0b busy=%0b lvl=%0d cnt=%0d empty=%0b tt=%0d want 0 0 0 0 1 0",
                     start, busy, level, seg_count, empty, target_time);
        end
        enable = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_enable_gating();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_seq.md
Name: stepper_seq

Overview:
Segment scheduler that sits in front of stepper_ctrl and sequences it.
- The host pushes motion segments (time, position, relative flag) into an internal FIFO.
- The sequencer pops one segment, drives stepper_ctrl's target_time, target_position and relative, and pulses start.
- On stepper_ctrl's done pulse it issues the next segment back-to-back.
- Reports FIFO level, busy, sticky overflow/underrun and a completed-segment count.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
AW, 4, log2(DEPTH).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  allow issuing new segments; an in-flight segment always completes
abort  in  1  synchronous flush: empty FIFO, return to IDLE
wr_en  in  1  push segment
wr_time  in  32  segment duration in clk cycles
wr_position  in  32  target position, signed; absolute or relative
wr_relative  in  1  segment is relative
clr_flags  in  1  clear overflow and underrun
done  in  1  one-cycle pulse from stepper_ctrl at segment end
start  out  1  one-cycle pulse to stepper_ctrl
target_time  out  32  to stepper_ctrl
target_position  out  32  to stepper_ctrl
relative  out  1  to stepper_ctrl
busy  out  1  a segment is in flight (state RUN)
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  AW+1  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underrun  out  1  sticky: done arrived with enable=1 and FIFO empty
seg_count  out  32  count of done pulses accepted in RUN, wraps at 2^32

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; start=0; target_time, target_position, relative, busy, overflow, underrun, seg_count and level all 0; empty=1; full=0; FIFO pointers 0. FIFO storage is not reset.
- FIFO write: the entry is accepted when wr_en=1 and full=0 (registered full, as seen before the edge). A write while full is dropped and sets overflow. A pop in the same cycle does not make room for that write.
- level increments on a write, decrements on a pop, and is unchanged when both happen in the same cycle. Pointers wrap modulo DEPTH.
- State IDLE:
  - If enable=1 and empty=0: latch the head entry into target_*/relative, pop, assert start for 1 cycle, go to RUN.
  - A write into an empty FIFO while enabled gives start high in the cycle after the write edge (1-cycle latency from wr_en).
- State RUN (busy=1): wait for done.
  - On done: seg_count++.
  - Then, if enable=1 and empty=0: latch the next head entry, pop, start=1 in the next cycle, stay in RUN. Latency from done to start is exactly 1 cycle.
  - Else: go to IDLE. If enable=1 (FIFO was empty), also set underrun.
- done while IDLE is ignored: no count, no flag.
- start is never high two consecutive cycles. target_*/relative hold their value until the next issue.
- abort=1 has priority over everything:
  - Next cycle: state=IDLE, start=0, FIFO empty, level=0, and a same-cycle write is discarded.
  - seg_count, flags and target_* hold. The caller is responsible for halting stepper_ctrl.
  - If a done coincides with abort, it is not counted.
- clr_flags clears overflow and underrun. If a set event occurs in the same cycle, the set wins.
- enable deasserted in RUN: the current segment finishes. On its done the block goes to IDLE without setting underrun, and the FIFO contents are kept.
- Reset asserted mid-segment: all outputs go to their reset values immediately and queued segments are lost.

Test Plan:
- Single segment: enable=1, push (20000, 5, rel=0) -> start 1 cycle after the write, target_time=20000, target_position=5, busy=1; done pulse -> busy=0 next cycle, seg_count=1, underrun=1.
- Back-to-back chain: push (50000,-15,0), (17000,-10,0), (50000,10,0), (10000,10,1), (15000,-20,1) -> each done yields start exactly 1 cycle later with the next values in order (relative=1 on the last two); seg_count=5; level steps 4..0.
- Overflow: enable=0, push 17 entries with DEPTH=16 -> full=1, level=16, overflow=1; 17th entry absent. Then enable=1 -> 16 segments issued in order.
- Enable gating: 3 queued, drop enable during segment 1 -> on done, IDLE, no underrun, level=2; re-enable -> start next cycle with entry 2.
- Abort: 4 queued, RUN, assert abort together with wr_en and done -> IDLE, level=0, seg_count unchanged, no further start.
- Async reset mid-RUN: drive reset=0 between clock edges -> start, busy, level and seg_count read 0 before the next edge.
